// File: rtl/game_tick_timer_if.sv
// Timer control/status bundle between the game FSM and game_tick_timer.
// Latency: none (wires only).
// Backpressure: none; start is a level request that the timer samples only when idle.
//
// master: game FSM side (drives start/duration/abort, observes status).
// slave : game_tick_timer side.
interface game_tick_timer_if #(
    parameter int DUR_W = 4
);
    logic             start;
    logic [DUR_W-1:0] duration;
    logic             abort;
    logic             tick;
    logic             busy;
    logic             done;
    logic [DUR_W-1:0] remaining;
    logic             stall;

    modport master (
        output start, duration, abort,
        input  tick, busy, done, remaining, stall
    );

    modport slave (
        input  start, duration, abort,
        output tick, busy, done, remaining, stall
    );
endinterface

// File: rtl/game_tick_timer.sv
// Synchronizes game_clk, emits one-cycle ticks on its rising edges, and runs a tick-based duration timer.
// Latency: game_clk rise to tick = SYNC_STAGES+1 cycles; start to busy = 1 cycle; final tick to done = 1 cycle.
// Backpressure: none; start is ignored (not queued) unless the timer is idle.
//
// Ports:
//   clock, resetn (async, active-low)   board clock and reset
//   game_clk                            slow game clock, asynchronous to clock
//   tmr (game_tick_timer_if.slave)      start/duration/abort in; tick/busy/done/remaining/stall out
// Build option: define GAME_STALL_DETECT_EN to build the stalled-game_clk watchdog;
// otherwise stall is tied low.
module game_tick_timer #(
    parameter int SYNC_STAGES  = 2,        // must be >= 2
    parameter int DUR_W        = 4,
    parameter int STALL_CYCLES = 50000000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               game_clk,
    game_tick_timer_if.slave   tmr
);

    localparam logic [31:0] STALL_LIM = 32'(STALL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // game_clk synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   tick_q, tick_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], game_clk};
        prev_d = sync_q[SYNC_STAGES-1];
        // prev clears on reset, so a game_clk already high at release yields one tick.
        tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Duration timer FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [DUR_W-1:0] remaining_q, remaining_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_IDLE: begin
                // A tick landing in the accept cycle is deliberately not counted:
                // counting only happens in RUN.
                if (tmr.start) begin
                    if (tmr.duration != '0) begin
                        remaining_d = tmr.duration;
                        state_d     = ST_RUN;
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                // abort beats a coincident terminating tick, so no done follows.
                if (tmr.abort) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else if (tick_q) begin
                    // <= 1 rather than == 1 keeps remaining from ever wrapping.
                    if (remaining_q <= DUR_W'(1)) begin
                        remaining_d = '0;
                        state_d     = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - DUR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    assign tmr.tick      = tick_q;
    assign tmr.busy      = (state_q == ST_RUN);
    assign tmr.done      = (state_q == ST_DONE);
    assign tmr.remaining = remaining_q;

    // ------------------------------------------------------------------
    // Stalled game_clk watchdog
    // ------------------------------------------------------------------
`ifdef GAME_STALL_DETECT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_q, stall_d;

    always_comb begin
        if (tick_q) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q >= STALL_LIM) begin
            stall_cnt_d = stall_cnt_q;
        end else begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        // Looking at the next count lets stall drop in the cycle right after a tick.
        stall_d = (stall_cnt_d >= STALL_LIM);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign tmr.stall = stall_q;
`else
    // The limit only matters when the watchdog is built.
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^STALL_LIM;
    assign tmr.stall        = 1'b0;
`endif

endmodule

// File: tb/tb_game_tick_timer.sv
// Directed bench for game_tick_timer: stimulus pushes expected tick/done cycles into
// scoreboard queues, and a negedge monitor pops and compares whenever tick or done appears.
// Status values (busy/remaining/stall) are additionally checked at hand-computed cycles.
module tb_game_tick_timer;

    localparam int DUR_W = 4;
`ifdef GAME_STALL_DETECT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic clock;
    logic resetn;
    logic game_clk;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   tick_exp[$];
    int   done_exp[$];

    game_tick_timer_if #(.DUR_W(DUR_W)) tmr ();

    game_tick_timer #(
        .SYNC_STAGES (2),
        .DUR_W       (DUR_W),
        .STALL_CYCLES(20)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .game_clk(game_clk),
        .tmr     (tmr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle index: value seen at a negedge is the number of posedges so far.
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (resetn) begin
            while (tick_exp.size() > 0 && tick_exp[0] < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL tick_missed: pulse absent, expected at cycle %0d (now %0d)", tick_exp[0], cyc);
                void'(tick_exp.pop_front());
            end
            while (done_exp.size() > 0 && done_exp[0] < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_missed: pulse absent, expected at cycle %0d (now %0d)", done_exp[0], cyc);
                void'(done_exp.pop_front());
            end
            if (tmr.tick) begin
                n_chk++;
                if (tick_exp.size() > 0 && tick_exp[0] == cyc) begin
                    void'(tick_exp.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL tick_unexpected: tick at cycle %0d, expected next at %0d",
                             cyc, (tick_exp.size() > 0) ? tick_exp[0] : -1);
                end
            end
            if (tmr.done) begin
                n_chk++;
                if (done_exp.size() > 0 && done_exp[0] == cyc) begin
                    void'(done_exp.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL done_unexpected: done at cycle %0d, expected next at %0d",
                             cyc, (done_exp.size() > 0) ? done_exp[0] : -1);
                end
                check("busy_in_done_cycle", 32'(tmr.busy), 32'd0);
                check("remaining_in_done_cycle", 32'(tmr.remaining), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One game_clk period: 4 cycles high, 4 low. Tick shows 3 cycles after the rise is driven.
    task automatic gpulse(input bit exp_done);
        int r;
        r = cyc;
        game_clk = 1'b1;
        tick_exp.push_back(r + 3);
        if (exp_done) done_exp.push_back(r + 4);
        step(4);
        game_clk = 1'b0;
        step(4);
    endtask

    task automatic start_run(input logic [DUR_W-1:0] d);
        tmr.start    = 1'b1;
        tmr.duration = d;
        if (d == '0) done_exp.push_back(cyc + 1);
        step(1);
        tmr.start = 1'b0;
    endtask

    initial begin
        int r;
        n_chk        = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        game_clk     = 1'b1;
        tmr.start    = 1'b0;
        tmr.duration = '0;
        tmr.abort    = 1'b0;
        step(3);

        // Reset values
        check("rst_tick", 32'(tmr.tick), 32'd0);
        check("rst_busy", 32'(tmr.busy), 32'd0);
        check("rst_done", 32'(tmr.done), 32'd0);
        check("rst_remaining", 32'(tmr.remaining), 32'd0);
        check("rst_stall", 32'(tmr.stall), 32'd0);

        // game_clk already high at release: exactly one tick
        resetn = 1'b1;
        tick_exp.push_back(cyc + 3);
        step(4);
        game_clk = 1'b0;
        step(4);

        // 1. Free-running ticks
        repeat (3) gpulse(1'b0);

        // 2. Normal run, duration 3
        start_run(4'd3);
        check("run3_busy_after_start", 32'(tmr.busy), 32'd1);
        check("run3_rem_start", 32'(tmr.remaining), 32'd3);
        gpulse(1'b0);
        check("run3_rem_after_t1", 32'(tmr.remaining), 32'd2);
        gpulse(1'b0);
        check("run3_rem_after_t2", 32'(tmr.remaining), 32'd1);
        gpulse(1'b1);
        check("run3_rem_end", 32'(tmr.remaining), 32'd0);
        check("run3_busy_end", 32'(tmr.busy), 32'd0);

        // 3a. Zero duration
        start_run(4'd0);
        check("zero_busy", 32'(tmr.busy), 32'd0);
        step(1);
        check("zero_busy_after", 32'(tmr.busy), 32'd0);

        // Back-to-back zero runs: start held 3 cycles -> done at +1, ignored in DONE, again at +3
        tmr.start    = 1'b1;
        tmr.duration = 4'd0;
        done_exp.push_back(cyc + 1);
        done_exp.push_back(cyc + 3);
        step(3);
        tmr.start = 1'b0;
        step(1);
        check("b2b_busy", 32'(tmr.busy), 32'd0);

        // 3b. start while busy is ignored
        start_run(4'd2);
        gpulse(1'b0);
        check("ign_rem_after_t1", 32'(tmr.remaining), 32'd1);
        start_run(4'd5);
        check("ign_rem_after_start", 32'(tmr.remaining), 32'd1);
        check("ign_busy", 32'(tmr.busy), 32'd1);
        gpulse(1'b1);
        check("ign_busy_end", 32'(tmr.busy), 32'd0);

        // 4a. abort coincident with the terminating tick
        start_run(4'd1);
        r = cyc;
        game_clk = 1'b1;
        tick_exp.push_back(r + 3);
        step(3);
        tmr.abort = 1'b1;
        step(1);
        tmr.abort = 1'b0;
        game_clk  = 1'b0;
        check("abort_busy", 32'(tmr.busy), 32'd0);
        check("abort_rem", 32'(tmr.remaining), 32'd0);
        step(4);

        // abort while idle does nothing; a following start still works
        tmr.abort = 1'b1;
        step(1);
        tmr.abort = 1'b0;
        check("idle_abort_busy", 32'(tmr.busy), 32'd0);

        // 4b. tick in the start-accept cycle is not counted
        r = cyc;
        game_clk = 1'b1;
        tick_exp.push_back(r + 3);
        step(3);
        tmr.start    = 1'b1;
        tmr.duration = 4'd2;
        step(1);
        tmr.start = 1'b0;
        game_clk  = 1'b0;
        check("coinc_rem", 32'(tmr.remaining), 32'd2);
        check("coinc_busy", 32'(tmr.busy), 32'd1);
        step(4);
        gpulse(1'b0);
        check("coinc_rem_after_t1", 32'(tmr.remaining), 32'd1);
        gpulse(1'b1);
        check("coinc_busy_end", 32'(tmr.busy), 32'd0);

        // 5. Reset mid-run
        start_run(4'd3);
        gpulse(1'b0);
        check("rstrun_rem_before", 32'(tmr.remaining), 32'd2);
        resetn = 1'b0;
        #1;
        check("rstrun_busy", 32'(tmr.busy), 32'd0);
        check("rstrun_rem", 32'(tmr.remaining), 32'd0);
        check("rstrun_done", 32'(tmr.done), 32'd0);
        check("rstrun_tick", 32'(tmr.tick), 32'd0);
        check("rstrun_stall", 32'(tmr.stall), 32'd0);
        step(2);
        resetn = 1'b1;
        step(3);
        check("rstrun_busy_after", 32'(tmr.busy), 32'd0);
        check("rstrun_rem_after", 32'(tmr.remaining), 32'd0);

        // 6. Stall watchdog: last tick at T, counter clears in T+1, stall from T+21
        gpulse(1'b0);            // returns at T+5
        step(15);                // T+20
        check("stall_before_limit", 32'(tmr.stall), 32'd0);
        step(1);                 // T+21
        check("stall_at_limit", 32'(tmr.stall), 32'(STALL_ON));
        r = cyc;
        game_clk = 1'b1;
        tick_exp.push_back(r + 3);
        step(3);
        check("stall_in_tick_cycle", 32'(tmr.stall), 32'(STALL_ON));
        step(1);
        check("stall_after_tick", 32'(tmr.stall), 32'd0);
        game_clk = 1'b0;
        step(4);

        step(6);
        check("tick_queue_drained", 32'(tick_exp.size()), 32'd0);
        check("done_queue_drained", 32'(done_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_tick_timer.md
# game_tick_timer

Consumer end of the game clock: samples the slow `game_clk`, synchronizes it into the board `clock` domain, and emits one-cycle `tick` enables on its rising edges. It also provides a start/done duration timer measured in game ticks, which the game FSM uses for display and response windows. An optional watchdog flags a stalled `game_clk`.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `game_clk`. Minimum is 2.
- `DUR_W`, default 4: width of `duration` and `remaining`.
- `STALL_CYCLES`, default 50000000: the number of board clock cycles without a tick before `stall` asserts. The internal counter is 32 bits.
- `clock`, input, 1: board clock.
- `resetn`, input, 1: reset. Asynchronous, active-low; clock is `clock`.
- `game_clk`, input, 1: slow game clock, asynchronous to `clock`.
- `start`, input, 1: request to start the timer. Sampled only in IDLE.
- `duration`, input, DUR_W: timer length in ticks. Captured on an accepted `start`.
- `abort`, input, 1: cancels a running timer.
- `tick`, output, 1: one-cycle pulse per `game_clk` rising edge.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when the timer expires.
- `remaining`, output, DUR_W: ticks left in the current run.
- `stall`, output, 1: watchdog flag.

## Operation
- **Reset values:** all outputs are 0 on reset. The synchronizer chain, edge register and watchdog counter all clear. The state is IDLE.
- **Edge detect:**
  - `game_clk` passes through a chain of SYNC_STAGES flops.
  - A `prev` register holds the last chain output.
  - `tick` is the registered value of (last stage AND NOT `prev`).
  - Falling edges produce nothing.
  - If `game_clk` is already high when reset is released, exactly one tick is produced.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `start` with `duration` != 0: load `remaining` = `duration` and go to RUN.
  - `start` with `duration` == 0: go straight to DONE; `remaining` stays 0.
- **RUN:**
  - `busy` = 1.
  - Each `tick` decrements `remaining`.
  - A `tick` while `remaining` == 1: `remaining` becomes 0 and the state goes to DONE.
  - `abort`: go to IDLE with `remaining` = 0, and no `done`.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE.
- **`start` acceptance:** ignored in RUN and DONE; it is not queued.
- **`abort` outside RUN:** no effect.
- **Simultaneous events:**
  - `abort` together with the terminating tick: `abort` wins and there is no `done`.
  - A `tick` in the same cycle that `start` is accepted is not counted. Counting begins the following cycle.
- **Arithmetic:** `remaining` never wraps below 0.
- **Asynchronous reset mid-run:** returns to IDLE immediately, with no `done`.

## Timing
- Let N be the first `clock` edge that samples `game_clk` = 1. `tick` is high for the single cycle after edge N+SYNC_STAGES. Latency is SYNC_STAGES+1 cycles.
- `start` to `busy`: `busy` is high in the cycle after the accepting edge.
- Expiry: `done` is high in the cycle after the edge where the final tick is consumed. `busy` falls in that same cycle.
- Zero duration: `done` is high in the cycle after `start`, and `busy` never rises.
- Back-to-back runs: `start` is accepted again from the first IDLE cycle, i.e. the cycle after `done`.
- Minimum supported `game_clk` high and low time: SYNC_STAGES+1 `clock` cycles each.

## Configuration
- `GAME_STALL_DETECT_EN` defined:
  - A 32-bit counter increments every cycle and clears on `tick`.
  - It saturates at STALL_CYCLES.
  - `stall` is registered high while the counter is >= STALL_CYCLES.
  - `stall` clears in the cycle after the next `tick`.
  - `stall` does not affect the FSM.
- `GAME_STALL_DETECT_EN` undefined: no counter is built and `stall` is tied to 0.

## Test plan
All scenarios use SYNC_STAGES=2, DUR_W=4 and STALL_CYCLES=20. `game_clk` runs with period 8 `clock` cycles (4 high, 4 low).

1. **Free-running ticks:** `game_clk` toggling with no other activity -> exactly one 1-cycle `tick` per `game_clk` rising edge, 3 cycles after the first sampling edge. No tick on falling edges.
2. **Normal run:** `start` with `duration`=3 in IDLE -> `busy`=1 next cycle; `remaining` reads 3,2,1,0 on successive ticks. `done` pulses once in the cycle after the 3rd tick, with `busy`=0 in that same cycle.
3. **Zero duration and start while busy:** `start` with `duration`=0 -> `done` pulses one cycle after `start` and `busy` stays 0. `start` with `duration`=5 asserted mid-run of a `duration`=2 run -> ignored; that run ends after 2 ticks.
4. **Abort races:** `abort` in the same cycle as the terminating tick of a `duration`=1 run -> IDLE, `remaining`=0, no `done`. A `tick` coincident with an accepted `start` is not counted.
5. **Reset mid-run:** `resetn`=0 while `remaining`=2 -> all outputs 0 immediately; after release the FSM is IDLE and there is no `done`.
6. **Stall (macro defined):** hold `game_clk` low -> `stall`=1 once 20 cycles have elapsed since the last tick. Resume toggling -> `stall`=0 the cycle after the next `tick`. With the macro undefined, `stall` stays 0 throughout.
